sram_burst_ctrl: RTL and testbench

SRAM_BURST_CTRL -- requirements
Module: sram_burst_ctrl

---
 rtl/sram_pkg.sv | 17 +
 rtl/sram_burst_ctrl.sv | 165 ++++++++++++++++
 tb/tb_sram_burst_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_pkg.sv
// Shared definitions for the SRAM burst controller.
//   state_t      : controller states (IDLE, READ, WRITE, DONE)
//   SRAM_DQ_W    : SRAM data bus width (one beat)
//   SRAM_ADDR_W  : SRAM halfword address width
package sram_pkg;

    localparam int SRAM_DQ_W   = 16;
    localparam int SRAM_ADDR_W = 18;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/sram_burst_ctrl.sv
// SRAM burst controller: moves one line of BURST_LEN words of DATA_W bits
// between the CPU side and a 16-bit asynchronous SRAM, one halfword beat at
// a time, each beat lasting WAIT_CYC clock cycles.
//
// state | meaning
// IDLE  | waiting for rd_en / wr_en (wr_en wins); request captured on exit
// READ  | N beats, SRAM_DQ sampled into the line on each beat's last cycle
// WRITE | N beats, line slice driven, SRAM_WE_N low except the hold cycle
// DONE  | single completion cycle with ready=1, then back to IDLE
//
// Ports
//   clk, rst        : clock, asynchronous active-high reset
//   rd_en, wr_en    : read (line fill) / write request
//   address         : byte address; bits [18:1] give the halfword address
//   wdata, rdata    : write line in, last completed read line out
//   ready           : low while a request is pending or in progress
//   SRAM_*          : SRAM data bus, halfword address and active-low controls
module sram_burst_ctrl
    import sram_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int BURST_LEN = 1,
    parameter int WAIT_CYC  = 6
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rd_en,
    input  logic                          wr_en,
    input  logic [31:0]                   address,
    input  logic [DATA_W*BURST_LEN-1:0]   wdata,
    output logic [DATA_W*BURST_LEN-1:0]   rdata,
    output logic                          ready,
    inout  wire  [SRAM_DQ_W-1:0]          SRAM_DQ,
    output logic [SRAM_ADDR_W-1:0]        SRAM_ADDR,
    output logic                          SRAM_UB_N,
    output logic                          SRAM_LB_N,
    output logic                          SRAM_WE_N,
    output logic                          SRAM_CE_N,
    output logic                          SRAM_OE_N
);

    localparam int BEATS_PER_WORD = DATA_W / SRAM_DQ_W;
    localparam int N              = BEATS_PER_WORD * BURST_LEN;
    localparam int LINE_W         = DATA_W * BURST_LEN;
    localparam int BEAT_W         = (N > 1) ? $clog2(N) : 1;
    localparam int CYC_W          = $clog2(WAIT_CYC);

    localparam logic [BEAT_W-1:0]      LAST_BEAT = BEAT_W'(N - 1);
    localparam logic [CYC_W-1:0]       LAST_CYC  = CYC_W'(WAIT_CYC - 1);
    localparam logic [SRAM_ADDR_W-1:0] BASE_MASK = ~(SRAM_ADDR_W'(N - 1));

    if (DATA_W < 16 || (DATA_W % 16) != 0) begin : g_bad_data_w
        $error("sram_burst_ctrl: DATA_W must be a multiple of 16 and at least 16");
    end
    if (BURST_LEN != 1 && BURST_LEN != 2 && BURST_LEN != 4 && BURST_LEN != 8) begin : g_bad_burst
        $error("sram_burst_ctrl: BURST_LEN must be 1, 2, 4 or 8");
    end
    if (WAIT_CYC < 2) begin : g_bad_wait
        $error("sram_burst_ctrl: WAIT_CYC must be at least 2");
    end

    state_t                  state_q, state_d;
    logic [CYC_W-1:0]        cyc_q;
    logic [BEAT_W-1:0]       beat_q;
    logic [SRAM_ADDR_W-1:0]  addr_q;
    logic [LINE_W-1:0]       line_q;
    logic [LINE_W-1:0]       line_rd;
    logic [LINE_W-1:0]       rdata_q;
    logic [SRAM_DQ_W-1:0]    wr_beat;
    logic                    cyc_last;
    logic                    beat_last;

    // Byte-lane bit 0 and the bits above the SRAM address range are not used.
    logic unused_addr;
    assign unused_addr = ^{address[31:19], address[0]};

    assign cyc_last  = (cyc_q == LAST_CYC);
    assign beat_last = (beat_q == LAST_BEAT);

    // The base is N-aligned and beat_q < N, so OR-ing wraps inside the block.
    assign SRAM_ADDR = addr_q | SRAM_ADDR_W'(beat_q);

    assign wr_beat   = line_q[int'(beat_q)*SRAM_DQ_W +: SRAM_DQ_W];
    assign SRAM_DQ   = (state_q == WRITE) ? wr_beat : {SRAM_DQ_W{1'bz}};

    // Last cycle of each write beat keeps the data on the bus with WE high.
    assign SRAM_WE_N = !((state_q == WRITE) && !cyc_last);

    assign SRAM_CE_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_OE_N = 1'b0;

    assign rdata = rdata_q;

    // Line with the current beat's bus value merged in.
    always_comb begin
        line_rd = line_q;
        line_rd[int'(beat_q)*SRAM_DQ_W +: SRAM_DQ_W] = SRAM_DQ;
    end

    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        case (state_q)
            IDLE: begin
                ready = !rd_en && !wr_en;
                if (wr_en) begin
                    state_d = WRITE;
                end else if (rd_en) begin
                    state_d = READ;
                end
            end
            READ, WRITE: begin
                if (cyc_last && beat_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                ready   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cyc_q   <= '0;
            beat_q  <= '0;
            addr_q  <= '0;
            line_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (rd_en || wr_en) begin
                        addr_q <= address[18:1] & BASE_MASK;
                        line_q <= wdata;
                        cyc_q  <= '0;
                        beat_q <= '0;
                    end
                end
                READ, WRITE: begin
                    if (cyc_last) begin
                        cyc_q  <= '0;
                        beat_q <= beat_last ? '0 : beat_q + 1'b1;
                        if (state_q == READ) begin
                            line_q <= line_rd;
                            if (beat_last) begin
                                rdata_q <= line_rd;
                            end
                        end
                    end else begin
                        cyc_q <= cyc_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_burst_ctrl.sv
// Bench for sram_burst_ctrl. Two instances: (32,1,6) and (32,4,2).
// A transaction-level model predicts every output each cycle from the
// elapsed time inside the current request; an SRAM model serves the bus.
module tb_sram_burst_ctrl;

    localparam int NB [2] = '{2, 8};     // beats per request
    localparam int WC [2] = '{6, 2};     // cycles per beat

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         rd_s   [2];
    logic         wr_s   [2];
    logic [31:0]  addr_s [2];
    logic [127:0] wd_s   [2];

    logic [31:0]  rdata0;
    logic [127:0] rdata1;
    logic         ready0, ready1, we0, we1;
    logic [17:0]  sa0, sa1;
    logic         ub0, lb0, ce0, oe0, ub1, lb1, ce1, oe1;
    wire  [15:0]  dq0, dq1;

    logic         drv_en  [2];
    logic [15:0]  drv_val [2];
    assign dq0 = drv_en[0] ? drv_val[0] : 16'hzzzz;
    assign dq1 = drv_en[1] ? drv_val[1] : 16'hzzzz;

    sram_burst_ctrl #(.DATA_W(32), .BURST_LEN(1), .WAIT_CYC(6)) u_a (
        .clk(clk), .rst(rst), .rd_en(rd_s[0]), .wr_en(wr_s[0]),
        .address(addr_s[0]), .wdata(wd_s[0][31:0]), .rdata(rdata0),
        .ready(ready0), .SRAM_DQ(dq0), .SRAM_ADDR(sa0),
        .SRAM_UB_N(ub0), .SRAM_LB_N(lb0), .SRAM_WE_N(we0),
        .SRAM_CE_N(ce0), .SRAM_OE_N(oe0));

    sram_burst_ctrl #(.DATA_W(32), .BURST_LEN(4), .WAIT_CYC(2)) u_b (
        .clk(clk), .rst(rst), .rd_en(rd_s[1]), .wr_en(wr_s[1]),
        .address(addr_s[1]), .wdata(wd_s[1]), .rdata(rdata1),
        .ready(ready1), .SRAM_DQ(dq1), .SRAM_ADDR(sa1),
        .SRAM_UB_N(ub1), .SRAM_LB_N(lb1), .SRAM_WE_N(we1),
        .SRAM_CE_N(ce1), .SRAM_OE_N(oe1));

    int errors = 0;
    int checks = 0;

    // reference model state
    bit           m_busy [2];
    bit           m_done [2];
    bit           m_wr   [2];
    int           m_t    [2];
    logic [17:0]  m_base [2];
    logic [127:0] m_line [2];
    logic [127:0] m_rdata[2];

    logic [15:0]  ref_mem  [int];
    logic [15:0]  sram_mem [int];
    logic [17:0]  addr_log [$];

    function automatic logic        get_ready(int i); return (i == 0) ? ready0 : ready1; endfunction
    function automatic logic        get_we(int i);    return (i == 0) ? we0 : we1; endfunction
    function automatic logic [17:0] get_sa(int i);    return (i == 0) ? sa0 : sa1; endfunction
    function automatic logic [15:0] get_dq(int i);    return (i == 0) ? dq0 : dq1; endfunction
    function automatic logic [127:0] get_rdata(int i);
        return (i == 0) ? {96'b0, rdata0} : rdata1;
    endfunction
    function automatic logic [3:0] get_const(int i);
        return (i == 0) ? {ub0, lb0, ce0, oe0} : {ub1, lb1, ce1, oe1};
    endfunction
    function automatic logic [127:0] lmask(int i);
        return (i == 0) ? 128'hFFFF_FFFF : {128{1'b1}};
    endfunction

    function automatic int key(int i, logic [17:0] a);
        return (i << 20) | int'(a);
    endfunction
    function automatic logic [15:0] ref_read(int i, logic [17:0] a);
        return ref_mem.exists(key(i, a)) ? ref_mem[key(i, a)] : (a[15:0] ^ 16'h5A5A);
    endfunction
    function automatic logic [15:0] sram_read(int i, logic [17:0] a);
        return sram_mem.exists(key(i, a)) ? sram_mem[key(i, a)] : (a[15:0] ^ 16'h5A5A);
    endfunction

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // advance one clock: a request occupies N*W cycles, then one DONE cycle
    task automatic model_step(int i);
        logic [17:0] a;
        if (m_done[i]) begin
            m_done[i] = 1'b0;
        end else if (m_busy[i]) begin
            m_t[i]++;
            if (m_t[i] == NB[i] * WC[i]) begin
                m_busy[i] = 1'b0;
                m_done[i] = 1'b1;
                for (int k = 0; k < NB[i]; k++) begin
                    a = m_base[i] + 18'(k);
                    if (m_wr[i]) ref_mem[key(i, a)] = m_line[i][16*k +: 16];
                    else         m_rdata[i][16*k +: 16] = ref_read(i, a);
                end
            end
        end else if (wr_s[i] || rd_s[i]) begin
            m_busy[i] = 1'b1;
            m_wr[i]   = wr_s[i];
            m_t[i]    = 0;
            m_base[i] = addr_s[i][18:1] & ~18'(NB[i] - 1);
            m_line[i] = wd_s[i] & lmask(i);
        end
    endtask

    task automatic update_drive();
        for (int i = 0; i < 2; i++) begin
            if (m_busy[i] && m_wr[i]) begin
                drv_en[i] = 1'b0;
            end else begin
                drv_en[i]  = 1'b1;
                drv_val[i] = m_busy[i] ? sram_read(i, get_sa(i)) : 16'($urandom);
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        if (!rst) begin
            for (int i = 0; i < 2; i++) model_step(i);
        end
        #1;
        update_drive();
    endtask

    // behavioural SRAM: stores the bus while WE_N is low
    always @(posedge clk) begin
        if (!rst) begin
            if (!we0) sram_mem[key(0, sa0)] = dq0;
            if (!we1) sram_mem[key(1, sa1)] = dq1;
        end
    end

    task automatic check_outputs(int i);
        int k, c;
        chk($sformatf("ready[%0d]", i), get_ready(i),
            m_done[i] || (!m_busy[i] && !rd_s[i] && !wr_s[i]));
        if (m_busy[i]) begin
            k = m_t[i] / WC[i];
            c = m_t[i] % WC[i];
            chk($sformatf("sram_addr[%0d]", i), get_sa(i), m_base[i] + 18'(k));
            chk($sformatf("we_n[%0d]", i), get_we(i), m_wr[i] ? (c == WC[i] - 1) : 1'b1);
            if (m_wr[i]) chk($sformatf("dq_write[%0d]", i), get_dq(i), m_line[i][16*k +: 16]);
            else         chk($sformatf("dq_hiz_read[%0d]", i), get_dq(i), drv_val[i]);
        end else begin
            chk($sformatf("we_n_idle[%0d]", i), get_we(i), 1'b1);
            chk($sformatf("dq_hiz[%0d]", i), get_dq(i), drv_val[i]);
        end
        chk($sformatf("rdata[%0d]", i), get_rdata(i), m_rdata[i] & lmask(i));
        chk($sformatf("ctrl_const[%0d]", i), get_const(i), 4'b0000);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            check_outputs(0);
            check_outputs(1);
        end
    end

    task automatic apply_reset_now();
        logic [17:0] a;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            // contents of an aborted write are whatever the SRAM holds
            if (m_busy[i] && m_wr[i]) begin
                for (int k = 0; k < NB[i]; k++) begin
                    a = m_base[i] + 18'(k);
                    ref_mem[key(i, a)] = sram_read(i, a);
                end
            end
            m_busy[i] = 0; m_done[i] = 0; m_wr[i] = 0; m_t[i] = 0;
            m_base[i] = '0; m_line[i] = '0; m_rdata[i] = '0;
            drv_en[i]  = 1'b1;
            drv_val[i] = 16'($urandom);
        end
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst_we_n[%0d]", i), get_we(i), 1'b1);
            chk($sformatf("rst_dq_hiz[%0d]", i), get_dq(i), drv_val[i]);
            chk($sformatf("rst_ready[%0d]", i), get_ready(i), !rd_s[i] && !wr_s[i]);
            chk($sformatf("rst_addr[%0d]", i), get_sa(i), 18'h0);
            chk($sformatf("rst_rdata[%0d]", i), get_rdata(i), 128'h0);
        end
    endtask

    task automatic release_reset();
        @(posedge clk);
        #3;
        rst = 1'b0;
    endtask

    // issue one request and follow it to its DONE cycle
    task automatic do_req(input int i, input bit w, input bit r, input logic [31:0] a,
                          input logic [127:0] d, output int lows, output int pulses,
                          output logic [127:0] rd_done);
        logic prev_we;
        rd_s[i] = r; wr_s[i] = w; addr_s[i] = a; wd_s[i] = d;
        cycle();
        rd_s[i] = 1'b0; wr_s[i] = 1'b0;
        addr_s[i] = $urandom; wd_s[i] = {$urandom, $urandom, $urandom, $urandom};
        lows = 0; pulses = 0; prev_we = 1'b1;
        addr_log.delete();
        for (int c = 0; c < 100; c++) begin
            #1;
            if (get_ready(i)) break;
            lows++;
            addr_log.push_back(get_sa(i));
            if (!get_we(i) && prev_we) pulses++;
            prev_we = get_we(i);
            cycle();
        end
        chk("done_reached", get_ready(i), 1'b1);
        rd_done = get_rdata(i);
        cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lows, pulses, d1, d2;
        logic [127:0] rdl, rd2;
        for (int i = 0; i < 2; i++) begin
            rd_s[i] = 0; wr_s[i] = 0; addr_s[i] = '0; wd_s[i] = '0;
            drv_en[i] = 1'b1; drv_val[i] = 16'h0;
            m_busy[i] = 0; m_done[i] = 0; m_wr[i] = 0; m_t[i] = 0;
            m_base[i] = '0; m_line[i] = '0; m_rdata[i] = '0;
        end
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("reset_ready", ready0, 1'b1);
        chk("reset_rdata", rdata0, 32'h0);
        chk("reset_we_n", we0, 1'b1);
        chk("reset_sram_addr", sa0, 18'h0);
        chk("reset_rdata_b", rdata1, 128'h0);

        // write 0xDEADBEEF to 0x8: beats at 0x4 / 0x5, 12 busy cycles
        do_req(0, 1, 0, 32'h0000_0008, 128'hDEAD_BEEF, lows, pulses, rdl);
        chk("wr_busy_cycles", lows, 12);
        chk("wr_we_pulses", pulses, 2);
        chk("wr_first_addr", addr_log[0], 18'h4);
        chk("wr_last_addr", addr_log[11], 18'h5);
        chk("wr_mem_lo", sram_read(0, 18'h4), 16'hBEEF);
        chk("wr_mem_hi", sram_read(0, 18'h5), 16'hDEAD);

        // read it back; must survive a later write
        do_req(0, 0, 1, 32'h0000_0008, 128'h0, lows, pulses, rdl);
        chk("rd_busy_cycles", lows, 12);
        chk("rd_line", rdl, 128'hDEAD_BEEF);
        do_req(0, 1, 0, 32'h0000_0020, 128'h1234_5678, lows, pulses, rdl);
        chk("rdata_hold_after_write", rdata0, 32'hDEAD_BEEF);

        // burst of 8 beats, 0x1C -> aligned block 0x8..0xF
        do_req(1, 0, 1, 32'h0000_001C, 128'h0, lows, pulses, rdl);
        chk("burst_busy_cycles", lows, 16);
        chk("burst_first_addr", addr_log[0], 18'h8);
        chk("burst_last_addr", addr_log[15], 18'hF);
        for (int j = 0; j < 16 && j < addr_log.size(); j++)
            chk("burst_addr_seq", addr_log[j], 18'(8 + j / 2));

        // simultaneous rd_en and wr_en: a write
        do_req(0, 1, 1, 32'h0000_0030, 128'hCAFE_F00D, lows, pulses, rdl);
        chk("both_we_pulses", pulses, 2);
        chk("both_mem_lo", sram_read(0, 18'h18), 16'hF00D);
        chk("both_mem_hi", sram_read(0, 18'h19), 16'hCAFE);
        chk("both_rdata_kept", rdl, 128'hDEAD_BEEF);

        // reset during cycle 3 of beat 1 of a write
        wr_s[0] = 1; addr_s[0] = 32'h0000_0040; wd_s[0] = 128'h1111_2222;
        cycle();
        wr_s[0] = 0;
        repeat (9) cycle();
        #2;
        chk("pre_rst_we_n", we0, 1'b0);
        chk("pre_rst_dq", dq0, 16'h1111);
        apply_reset_now();
        release_reset();
        do_req(0, 0, 1, 32'h0000_0008, 128'h0, lows, pulses, rdl);
        chk("post_rst_busy", lows, 12);
        chk("post_rst_read", rdl, 128'hDEAD_BEEF);

        // back-to-back reads with the request held
        rd_s[0] = 1; wr_s[0] = 0; addr_s[0] = 32'h0000_0030;
        d1 = -1; d2 = -1; rd2 = '0;
        for (int c = 0; c < 60 && d2 < 0; c++) begin
            #1;
            if (ready0) begin
                if (d1 < 0) d1 = c;
                else begin d2 = c; rd2 = {96'b0, rdata0}; end
            end
            cycle();
        end
        rd_s[0] = 0;
        chk("b2b_first_done", d1, 13);
        chk("b2b_gap", d2 - d1, 14);
        chk("b2b_rdata", rd2, 128'hCAFE_F00D);
        repeat (20) cycle();

        // randomized traffic on both instances
        for (int n = 0; n < 900; n++) begin
            for (int i = 0; i < 2; i++) begin
                rd_s[i]   = ($urandom_range(0, 2) == 0);
                wr_s[i]   = ($urandom_range(0, 3) == 0);
                addr_s[i] = $urandom & 32'hFFFC_00FF;
                wd_s[i]   = {$urandom, $urandom, $urandom, $urandom};
            end
            if (n == 450) begin
                #2;
                apply_reset_now();
                release_reset();
            end
            cycle();
        end
        for (int i = 0; i < 2; i++) begin rd_s[i] = 0; wr_s[i] = 0; end
        repeat (40) cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
